// File: rtl/note_player.sv
// note_player: latches a MIDI note number and plays it as a square wave on
// tone_out for NOTE_CYCLES clocks. Notes 60..76 are audible. Any other note
// raises a one-cycle note_err and is timed as a silent rest.
// Build macro NOTE_GAP_EN adds a GAP state of GAP_CYCLES silent clocks after
// each note. Without the macro the GAP state and its counter do not exist.
module note_player #(
  parameter int NOTE_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 2500000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       data_en,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tone_out,
  output logic       playing,
  output logic       note_err
);

  // Reject out-of-range timing parameters when the design is elaborated.
  if (NOTE_CYCLES < 2 || NOTE_CYCLES > 67108863 ||
      GAP_CYCLES < 1 || GAP_CYCLES > 67108863) begin : g_bad_param
    $error("note_player: NOTE_CYCLES or GAP_CYCLES out of range");
  end

  localparam logic [25:0] NOTE_LAST = 26'(NOTE_CYCLES - 1);

`ifdef NOTE_GAP_EN
  localparam logic [25:0] GAP_LAST = 26'(GAP_CYCLES - 1);
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_PLAY} state_t;
`endif

  state_t      r_state;
  state_t      w_state_next;
  logic [25:0] r_dur_cnt;
  logic [16:0] r_hp_cnt;
  logic [7:0]  r_note;
  logic        r_tone;
  logic        r_err;
  logic        w_accept;
  logic        w_supported;
  logic        w_dur_done;
  logic        w_hp_done;
  logic [16:0] w_hp_last;

  // Half period in clocks, round(25e6 / f(n)), for the supported range.
  function automatic logic [16:0] hp_lookup(input logic [7:0] n);
    case (n)
      8'd60:   hp_lookup = 17'd95556;
      8'd61:   hp_lookup = 17'd90193;
      8'd62:   hp_lookup = 17'd85131;
      8'd63:   hp_lookup = 17'd80353;
      8'd64:   hp_lookup = 17'd75843;
      8'd65:   hp_lookup = 17'd71586;
      8'd66:   hp_lookup = 17'd67569;
      8'd67:   hp_lookup = 17'd63776;
      8'd68:   hp_lookup = 17'd60197;
      8'd69:   hp_lookup = 17'd56818;
      8'd70:   hp_lookup = 17'd53629;
      8'd71:   hp_lookup = 17'd50619;
      8'd72:   hp_lookup = 17'd47778;
      8'd73:   hp_lookup = 17'd45097;
      8'd74:   hp_lookup = 17'd42566;
      8'd75:   hp_lookup = 17'd40177;
      8'd76:   hp_lookup = 17'd37922;
      default: hp_lookup = 17'd1;
    endcase
  endfunction

  assign w_accept    = data_en && (r_state == S_IDLE);
  assign w_supported = (r_note >= 8'd60) && (r_note <= 8'd76);
  assign w_dur_done  = (r_dur_cnt == NOTE_LAST);
  assign w_hp_last   = hp_lookup(r_note) - 17'd1;
  assign w_hp_done   = (r_hp_cnt == w_hp_last);

`ifdef NOTE_GAP_EN
  logic [25:0] r_gap_cnt;
  logic        w_gap_done;
  assign w_gap_done = (r_gap_cnt == GAP_LAST);

  // Gap counter: restarts as PLAY ends, counts while in GAP.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_gap_cnt <= '0;
    end else if (r_state == S_PLAY) begin
      r_gap_cnt <= '0;
    end else if (r_state == S_GAP) begin
      r_gap_cnt <= r_gap_cnt + 26'd1;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = S_PLAY;
`ifdef NOTE_GAP_EN
      S_PLAY: if (w_dur_done) w_state_next = S_GAP;
      S_GAP:  if (w_gap_done) w_state_next = S_IDLE;
`else
      S_PLAY: if (w_dur_done) w_state_next = S_IDLE;
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode; tone and error come straight from their registers.
  always_comb begin
    ready    = (r_state == S_IDLE);
    playing  = (r_state == S_PLAY);
    tone_out = r_tone;
    note_err = r_err;
  end

  // Note latch and single-cycle error flag, both only on acceptance.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_note <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_accept) begin
        r_note <= data;
        r_err  <= (data < 8'd60) || (data > 8'd76);
      end
    end
  end

  // Note duration counter, independent of the tone counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dur_cnt <= '0;
    end else if (w_accept || (r_state == S_PLAY && w_dur_done)) begin
      r_dur_cnt <= '0;
    end else if (r_state == S_PLAY) begin
      r_dur_cnt <= r_dur_cnt + 26'd1;
    end
  end

  // Half-period counter and tone toggle; note expiry wins over a toggle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hp_cnt <= '0;
      r_tone   <= 1'b0;
    end else if (w_accept || r_state != S_PLAY || w_dur_done) begin
      r_hp_cnt <= '0;
      r_tone   <= 1'b0;
    end else if (w_supported) begin
      if (w_hp_done) begin
        r_hp_cnt <= '0;
        r_tone   <= ~r_tone;
      end else begin
        r_hp_cnt <= r_hp_cnt + 17'd1;
      end
    end
  end

endmodule

// File: tb/tb_note_player.sv
// tb_note_player: directed checks of note_player on two instances,
// a short-note instance (50 clocks) and a long-note instance (40000 clocks)
// that lets note 76 (half period 37922) toggle once before expiring.
module tb_note_player;

  localparam int S_NOTE = 50;
  localparam int L_NOTE = 40000;
  localparam int GAP    = 10;
`ifdef NOTE_GAP_EN
  localparam int GAP_EXTRA = GAP;
`else
  localparam int GAP_EXTRA = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       s_resetn = 1'b0, s_data_en = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic       s_ready, s_tone, s_playing, s_err;
  logic       l_resetn = 1'b0, l_data_en = 1'b0;
  logic [7:0] l_data = 8'd0;
  logic       l_ready, l_tone, l_playing, l_err;

  note_player #(.NOTE_CYCLES(S_NOTE), .GAP_CYCLES(GAP)) u_short (
    .clk(clk), .resetn(s_resetn), .data_en(s_data_en), .data(s_data),
    .ready(s_ready), .tone_out(s_tone), .playing(s_playing), .note_err(s_err));

  note_player #(.NOTE_CYCLES(L_NOTE), .GAP_CYCLES(GAP)) u_long (
    .clk(clk), .resetn(l_resetn), .data_en(l_data_en), .data(l_data),
    .ready(l_ready), .tone_out(l_tone), .playing(l_playing), .note_err(l_err));

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Count rising edges of the short instance's playing output.
  int   s_rises  = 0;
  logic s_play_q = 1'b0;
  always @(negedge clk) begin
    if (s_playing && !s_play_q) s_rises <= s_rises + 1;
    s_play_q <= s_playing;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_s_ready(input string name);
    for (int k = 0; k < 300; k++) begin
      if (s_ready === 1'b1) break;
      tick();
    end
    check(name, 32'(s_ready), 32'd1);
  endtask

  typedef struct {
    logic [7:0] note;
    logic       err;
  } vec_t;

  vec_t vecs[10];
  logic [7:0] seq_note[5];
  logic       seq_err[5];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_busy, n_play, n_tone, n_errs, first_tone, last_acc, rises0;

    vecs[0] = '{8'd60,  1'b0};
    vecs[1] = '{8'd76,  1'b0};
    vecs[2] = '{8'd59,  1'b1};
    vecs[3] = '{8'd77,  1'b1};
    vecs[4] = '{8'd69,  1'b0};
    vecs[5] = '{8'd80,  1'b1};
    vecs[6] = '{8'd0,   1'b1};
    vecs[7] = '{8'd255, 1'b1};
    vecs[8] = '{8'd72,  1'b0};
    vecs[9] = '{8'd64,  1'b0};
    seq_note = '{8'd60, 8'd81, 8'd64, 8'd59, 8'd76};
    seq_err  = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0};

    // Reset state, with data_en already high on the short instance.
    s_data_en = 1'b1;
    s_data    = 8'd62;
    repeat (3) tick();
    check("rst_ready",   32'(s_ready),   32'd1);
    check("rst_playing", 32'(s_playing), 32'd0);
    check("rst_tone",    32'(s_tone),    32'd0);
    check("rst_err",     32'(s_err),     32'd0);
    check("rst_l_ready", 32'(l_ready),   32'd1);
    s_resetn = 1'b1;
    l_resetn = 1'b1;
    check("rel_no_accept_yet", 32'(s_playing), 32'd0);
    tick();
    check("first_edge_accept", 32'(s_playing), 32'd1);
    s_data_en = 1'b0;

    // Table: one note per record, timing and error pulse checked.
    for (int i = 0; i < 10; i++) begin
      wait_s_ready($sformatf("v%0d_ready", i));
      s_data_en = 1'b1;
      s_data    = vecs[i].note;
      tick();
      s_data_en = 1'b0;
      s_data    = 8'($urandom);
      check($sformatf("v%0d_note%0d_err", i, vecs[i].note), 32'(s_err), 32'(vecs[i].err));
      n_busy = 0; n_play = 0; n_tone = 0; n_errs = 0;
      for (int k = 0; k < 300; k++) begin
        if (s_ready === 1'b1) break;
        n_busy += 1;
        n_play += int'(s_playing);
        n_tone += int'(s_tone);
        n_errs += int'(s_err);
        tick();
      end
      check($sformatf("v%0d_busy", i), 32'(n_busy), 32'(S_NOTE + GAP_EXTRA));
      check($sformatf("v%0d_play", i), 32'(n_play), 32'(S_NOTE));
      check($sformatf("v%0d_tone", i), 32'(n_tone), 32'd0);
      check($sformatf("v%0d_errcnt", i), 32'(n_errs), 32'(vecs[i].err));
    end

    // data_en held high: one acceptance per IDLE visit, in order.
    rises0   = s_rises;
    last_acc = 0;
    s_data_en = 1'b1;
    s_data    = seq_note[0];
    for (int k = 0; k < 5; k++) begin
      wait_s_ready($sformatf("hold%0d_ready", k));
      s_data = seq_note[k];
      tick();
      check($sformatf("hold%0d_err", k), 32'(s_err), 32'(seq_err[k]));
      if (k > 0)
        check($sformatf("hold%0d_spacing", k), 32'(cyc - last_acc), 32'(S_NOTE + GAP_EXTRA + 1));
      last_acc = cyc;
      if (k < 4) s_data = seq_note[k+1];
      else begin
        s_data_en = 1'b0;
        s_data    = 8'd0;
      end
    end
    repeat (200) tick();
    check("hold_accept_count", 32'(s_rises - rises0), 32'd5);

    // Asynchronous reset in the middle of note 60.
    l_data_en = 1'b1;
    l_data    = 8'd60;
    tick();
    l_data_en = 1'b0;
    repeat (500) tick();
    check("mid_play_playing", 32'(l_playing), 32'd1);
    #2 l_resetn = 1'b0;
    #1;
    check("arst_playing", 32'(l_playing), 32'd0);
    check("arst_ready",   32'(l_ready),   32'd1);
    check("arst_tone",    32'(l_tone),    32'd0);
    tick();
    l_resetn = 1'b1;

    // Note 76 after reset, with data_en high and data changing while busy.
    l_data_en = 1'b1;
    l_data    = 8'd76;
    tick();
    n_busy = 0; n_play = 0; n_tone = 0; first_tone = -1;
    for (int k = 0; k < L_NOTE + 1000; k++) begin
      if (l_ready === 1'b1) break;
      if (l_tone === 1'b1 && first_tone < 0) first_tone = k;
      n_busy += 1;
      n_play += int'(l_playing);
      n_tone += int'(l_tone);
      l_data_en = (k < L_NOTE - 10);
      l_data    = 8'($urandom);
      tick();
    end
    l_data_en = 1'b0;
    check("n76_first_toggle", 32'(first_tone), 32'd37922);
    check("n76_tone_high",    32'(n_tone),     32'(L_NOTE - 37922));
    check("n76_play",         32'(n_play),     32'(L_NOTE));
    check("n76_busy",         32'(n_busy),     32'(L_NOTE + GAP_EXTRA));
    check("n76_exit_tone",    32'(l_tone),     32'd0);
    check("n76_exit_playing", 32'(l_playing),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/note_player.md
NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 The block SHALL have parameter NOTE_CYCLES, default 12500000, giving note duration in clk cycles (250 ms at 50 MHz); legal range 2 to 2^26-1.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 2500000, giving inter-note silence in clk cycles; used only with NOTE_GAP_EN; legal range 1 to 2^26-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the 50 MHz system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port data_en, input, 1 bit: note-valid from the note generator.
REQ-006 The block SHALL have port data, input, 8 bits: MIDI note number.
REQ-007 The block SHALL have port ready, output, 1 bit: the block can accept a note this cycle.
REQ-008 The block SHALL have port tone_out, output, 1 bit: square-wave audio output.
REQ-009 The block SHALL have port playing, output, 1 bit: high while a note or rest is being timed.
REQ-010 The block SHALL have port note_err, output, 1 bit: one-cycle pulse on accepting an unsupported note.

Function
REQ-011 A note SHALL be accepted on a rising edge where data_en=1 and ready=1, latching data; data is ignored at every other edge.
REQ-012 The block SHALL implement FSM states IDLE, PLAY and GAP, with ready=1 only in IDLE.
REQ-013 Transition IDLE->PLAY SHALL occur on acceptance; playing SHALL be high from the next cycle for exactly NOTE_CYCLES cycles.
REQ-014 Leaving PLAY SHALL go to GAP when NOTE_GAP_EN is defined, otherwise to IDLE.
REQ-015 Supported notes SHALL be 60..76 (C4..E5); half-period HP(n) SHALL be a 17-bit constant table round(25000000/(440*2^((n-69)/12))); anchors: 60->95556, 69->56818, 72->47778, 76->37922.
REQ-016 In PLAY with a supported note, the half-period counter SHALL start at 0 on acceptance and increment each cycle; when it equals HP-1 it SHALL clear and tone_out SHALL toggle.
REQ-017 tone_out SHALL be 0 in the first PLAY cycle, and SHALL be forced to 0 in IDLE and GAP and on every exit from PLAY.
REQ-018 An accepted note outside 60..76 SHALL pulse note_err for exactly one cycle, in the cycle after acceptance, and SHALL be played as a rest: PLAY timing unchanged, tone_out held 0.
REQ-019 The duration counter SHALL be independent of the half-period counter; NOTE_CYCLES expiry SHALL take precedence over a simultaneous tone toggle.
REQ-020 data_en held high continuously SHALL result in one accepted note per IDLE visit, with no note skipped or accepted twice.

Reset
REQ-021 The block SHALL enter IDLE immediately on assertion of resetn=0, including mid-note or mid-gap.
REQ-022 On reset the block SHALL drive ready=1, tone_out=0, playing=0 and note_err=0, and clear all counters and the latched note.
REQ-023 The first acceptance after reset release SHALL occur no earlier than the first rising edge with resetn=1.

Configuration
REQ-024 Macro NOTE_GAP_EN SHALL select gap behaviour: when defined, GAP lasts GAP_CYCLES cycles with ready=0, playing=0 and tone_out=0, then returns to IDLE.
REQ-025 When NOTE_GAP_EN is undefined, the GAP state and its counter SHALL be absent, and ready SHALL return to 1 the cycle after PLAY ends.

Verification
REQ-026 Scenario: NOTE_CYCLES=200000, data=69 accepted -> tone_out toggles every 56818 cycles (3 toggles), playing high 200000 cycles, then ready=1.
REQ-027 Scenario: data=80 accepted -> note_err=1 for one cycle, tone_out stays 0 for NOTE_CYCLES, playing high throughout.
REQ-028 Scenario: data_en held high with data stepping 60,64,68,72,76, NOTE_CYCLES=100 -> exactly five notes accepted in order, none repeated.
REQ-029 Scenario: resetn pulsed low mid-PLAY on note 60 -> same cycle tone_out=0, playing=0, ready=1; next accepted note plays normally.
REQ-030 Scenario: NOTE_GAP_EN defined, GAP_CYCLES=10, NOTE_CYCLES=50 -> ready low for 60 cycles after acceptance, tone_out 0 during gap.
REQ-031 Scenario: data_en=1 while ready=0 with data changing -> latched note unchanged and tone period unaffected.
